// File: rtl/cmp_serial.sv
// cmp_serial: multi-cycle WIDTH-bit magnitude comparator.
// It compares BPC bits per clock, starting with the LSB chunk. It supports
// unsigned and two's-complement operands and uses a start/busy/done handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        compare request, sampled only while busy=0
//   A, B         operands, sampled with start
//   signed_mode  0 = unsigned, 1 = two's complement, sampled with start
//   busy         compare in progress
//   done         one-cycle pulse: result outputs just updated
//   AgtBo        A > B for the last completed compare
//   AeqBo        A == B for the last completed compare
//   AltBo        A < B for the last completed compare
module cmp_serial #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned BPC   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             AgtBo,
   output logic             AeqBo,
   output logic             AltBo
);

   // Number of chunks and the width of the chunk counter (at least 1 bit).
   localparam int unsigned N  = WIDTH / ((BPC == 0) ? 1 : BPC);
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   // Stop elaboration when the parameters are illegal.
   if (WIDTH < 2 || BPC < 1 || BPC > WIDTH || (WIDTH % ((BPC == 0) ? 1 : BPC)) != 0) begin : g_param_check
      $error("cmp_serial: illegal WIDTH=%0d / BPC=%0d", WIDTH, BPC);
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sm_q, sm_d;
   logic             gt_q, gt_d;
   logic             eq_q, eq_d;
   logic             lt_q, lt_d;
   logic             busy_d, done_d;
   logic             agtb_d, aeqb_d, altb_d;

   // Current chunk selection and the running flags after this chunk.
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [BPC-1:0]   ca, cb;
   logic             last;
   logic             gt_n, eq_n, lt_n;

   always_comb begin
      a_sh = a_q >> (32'(cnt_q) * BPC);
      b_sh = b_q >> (32'(cnt_q) * BPC);
      ca   = a_sh[BPC-1:0];
      cb   = b_sh[BPC-1:0];
      last = (cnt_q == CW'(N - 1));
      // Flipping the sign bit maps two's complement onto offset binary. After
      // that, an unsigned compare of the top chunk gives the signed order.
      if (last && sm_q) begin
         ca[BPC-1] = ~ca[BPC-1];
         cb[BPC-1] = ~cb[BPC-1];
      end
      gt_n = gt_q;
      eq_n = eq_q;
      lt_n = lt_q;
      // A higher chunk that differs overrides whatever the lower chunks decided.
      if (ca > cb) begin
         gt_n = 1'b1;
         eq_n = 1'b0;
         lt_n = 1'b0;
      end else if (ca < cb) begin
         gt_n = 1'b0;
         eq_n = 1'b0;
         lt_n = 1'b1;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sm_d    = sm_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      busy_d  = busy;
      done_d  = 1'b0;
      agtb_d  = AgtBo;
      aeqb_d  = AeqBo;
      altb_d  = AltBo;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               sm_d    = signed_mode;
               cnt_d   = '0;
               gt_d    = 1'b0;
               eq_d    = 1'b1;
               lt_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            gt_d = gt_n;
            eq_d = eq_n;
            lt_d = lt_n;
            if (last) begin
               agtb_d  = gt_n;
               aeqb_d  = eq_n;
               altb_d  = lt_n;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State register. Reset aborts any compare in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sm_q    <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         AgtBo   <= 1'b0;
         AeqBo   <= 1'b0;
         AltBo   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sm_q    <= sm_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         busy    <= busy_d;
         done    <= done_d;
         AgtBo   <= agtb_d;
         AeqBo   <= aeqb_d;
         AltBo   <= altb_d;
      end
   end

endmodule
